fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the control unit.
- Owns the program counter (PC) and the instruction register (IR) that feeds the control unit's decoder.
- Fetches a word from program RAM over a req/ack handshake when the control unit asserts en_in (fetch state), and advances the PC on en_pc (increment state).
- Raises stall while a fetch is outstanding so the control unit's state counter is frozen (stall gates its ce externally).

Parameters:
AW, 4, address width; PC and mem_addr width.
DW, 8, instruction/data width; IR and mem_rdata width.
RESET_PC, 0, PC value after clr.
MAX_WAIT, 7, maximum cycles to wait for mem_rd_ack before aborting the fetch (1..255).
NOP_WORD, 8'h00, word loaded into IR on a fetch timeout.

Ports:
clk  in  1  system clock, rising-edge.
clr  in  1  reset, asynchronous, active-high.
ce  in  1  clock enable shared with the control unit; en_in, en_pc and jmp_en are honoured only when ce=1.
en_in  in  1  fetch strobe from the control unit.
en_pc  in  1  PC increment strobe from the control unit.
jmp_en  in  1  load PC from jmp_addr.
jmp_addr  in  AW  jump target.
mem_rd_req  out  1  read request to program RAM.
mem_addr  out  AW  read address; stable while mem_rd_req=1.
mem_rd_ack  in  1  RAM data valid; sampled only while mem_rd_req=1.
mem_rdata  in  DW  RAM read data.
ir  out  DW  instruction register, to the control unit's ir input.
pc  out  AW  current PC.
stall  out  1  fetch outstanding; external logic ANDs it into the control unit's ce.
fetch_done  out  1  one-cycle pulse: IR updated.
fetch_err  out  1  sticky timeout flag, cleared only by clr.

Behaviour:
- Reset (clr=1, async):
  - state=IDLE, pc=RESET_PC, ir=0, mem_addr=0.
  - mem_rd_req=0, stall=0, fetch_done=0, fetch_err=0, wait counter=0.
  - A clr during REQ drops the request immediately; any later ack is ignored.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states: IDLE, REQ.
  - IDLE -> REQ when ce&en_in. On that edge: mem_addr<=pc, mem_rd_req<=1, stall<=1, wait counter<=0.
  - REQ, mem_rd_ack=1: ir<=mem_rdata, mem_rd_req<=0, stall<=0, fetch_done<=1, go to IDLE.
  - REQ, mem_rd_ack=0, wait counter<MAX_WAIT-1: wait counter increments.
  - REQ, mem_rd_ack=0, wait counter=MAX_WAIT-1: ir<=NOP_WORD, fetch_err<=1, fetch_done<=1, mem_rd_req<=0, stall<=0, go to IDLE.
- REQ ignores ce and en_in; the request always completes.
- Latency: en_in sampled at edge N; req and stall high from N until the ack edge. With ack tied high, IR is updated at edge N+1 and fetch_done is high for cycle N+1..N+2. Minimum fetch is 1 stall cycle.
- fetch_done is deasserted on every cycle other than the completion cycle.
- PC update, evaluated only when ce=1 and state=IDLE, in priority order:
  1. jmp_en: pc<=jmp_addr.
  2. en_pc: pc<=pc+1, modulo 2^AW (2^AW-1 wraps to 0, no flag).
  3. Otherwise pc holds.
- Same-edge en_in and en_pc/jmp_en: mem_addr captures the old pc, and pc updates as well.
- In REQ, en_pc and jmp_en are dropped (not queued).
- An ack while in IDLE is ignored. mem_rdata is don't-care except on the ack edge.

Decomposition:
- Shared package proc_pkg holds: fetch state enum (IDLE, REQ), default widths AW=4 and DW=8, NOP_WORD, RESET_PC. The control unit and datapath use the same constants.
- One sub-module, pc_reg: AW-bit register with async clr, load (jmp) and increment, with load taking priority. It is reused later for the datapath address register.

Test Plan:
1. Reset then idle: pulse clr mid-cycle -> pc=0, ir=0, stall=0, mem_rd_req=0 immediately, before the next edge.
2. Zero-wait fetch: pc=3, RAM[3]=8'hA5, ack tied high, ce=1, en_in one cycle -> req and stall high for 1 cycle, mem_addr=3, ir=8'hA5, fetch_done pulses once.
3. Wait states: ack delayed 3 cycles -> stall high 4 cycles, mem_addr held at 3 throughout, en_pc pulsed during the stall ignored, pc still 3 after completion.
4. Timeout: ack never asserted, MAX_WAIT=7 -> after 7 REQ cycles ir=8'h00, fetch_err=1 (stays set), stall drops, fetch_done pulses.
5. Wrap and priority: pc=15, en_pc -> pc=0; then en_pc plus jmp_en with jmp_addr=9 on the same edge -> pc=9.
6. Reset mid-fetch: clr asserted during REQ with ack arriving 1 cycle after release -> mem_rd_req=0, ir=0, ack ignored, state IDLE, pc=RESET_PC.

Source files
------------

// File: rtl/proc_pkg.sv
// Constants and types shared by the fetch unit, control unit and datapath.
// Defaults here are the reference configuration of the small processor.
package proc_pkg;

   localparam int unsigned AW_DEF       = 4;
   localparam int unsigned DW_DEF       = 8;
   localparam int unsigned RESET_PC_DEF = 0;
   localparam int unsigned MAX_WAIT_DEF = 7;
   localparam logic [DW_DEF-1:0] NOP_WORD_DEF = 8'h00;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Address register with async clear, parallel load and increment (load wins).
// Used as the program counter here and as the datapath address register.
module pc_reg #(
   parameter int unsigned W         = 4,
   parameter logic [W-1:0] RESET_VAL = '0
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         ld,
   input  logic         inc,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] val_q, val_d;

   always_comb begin
      val_d = val_q;
      if (ld)
         val_d = d;
      else if (inc)
         val_d = val_q + W'(1);
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr)
         val_q <= RESET_VAL;
      else
         val_q <= val_d;
   end

   assign q = val_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC and IR, reads program RAM over req/ack,
// and stalls the control unit while a fetch is outstanding.
module fetch_unit
   import proc_pkg::*;
#(
   parameter int unsigned     AW       = AW_DEF,
   parameter int unsigned     DW       = DW_DEF,
   parameter int unsigned     RESET_PC = RESET_PC_DEF,
   parameter int unsigned     MAX_WAIT = MAX_WAIT_DEF,
   parameter logic [DW-1:0]   NOP_WORD = DW'(NOP_WORD_DEF)
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          ce,
   input  logic          en_in,
   input  logic          en_pc,
   input  logic          jmp_en,
   input  logic [AW-1:0] jmp_addr,
   output logic          mem_rd_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_rd_ack,
   input  logic [DW-1:0] mem_rdata,
   output logic [DW-1:0] ir,
   output logic [AW-1:0] pc,
   output logic          stall,
   output logic          fetch_done,
   output logic          fetch_err
);

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   fetch_state_e  state_q;
   logic [DW-1:0] ir_q;
   logic [AW-1:0] addr_q;
   logic          req_q;
   logic          stall_q;
   logic          done_q;
   logic          err_q;
   logic [7:0]    wait_q;
   logic [AW-1:0] pc_q;
   logic          pc_ld, pc_inc, pc_upd;

   // PC strobes are dropped (not queued) while a fetch is outstanding.
   assign pc_upd = ce && (state_q == IDLE);
   assign pc_ld  = pc_upd && jmp_en;
   assign pc_inc = pc_upd && en_pc;

   pc_reg #(
      .W         (AW),
      .RESET_VAL (AW'(RESET_PC))
   ) u_pc (
      .clk (clk),
      .clr (clr),
      .ld  (pc_ld),
      .inc (pc_inc),
      .d   (jmp_addr),
      .q   (pc_q)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= IDLE;
         ir_q    <= '0;
         addr_q  <= '0;
         req_q   <= 1'b0;
         stall_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         wait_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (ce && en_in) begin
                  addr_q  <= pc_q;
                  req_q   <= 1'b1;
                  stall_q <= 1'b1;
                  wait_q  <= '0;
                  state_q <= REQ;
               end
            end
            REQ: begin
               // Once issued, a request runs to ack or timeout regardless of ce.
               if (mem_rd_ack) begin
                  ir_q    <= mem_rdata;
                  req_q   <= 1'b0;
                  stall_q <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end else if (wait_q == WAIT_LAST) begin
                  ir_q    <= NOP_WORD;
                  err_q   <= 1'b1;
                  req_q   <= 1'b0;
                  stall_q <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  wait_q <= wait_q + 8'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_rd_req = req_q;
   assign mem_addr   = addr_q;
   assign ir         = ir_q;
   assign pc         = pc_q;
   assign stall      = stall_q;
   assign fetch_done = done_q;
   assign fetch_err  = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: transaction-level model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_fetch_unit;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int MAXW = 7;

   logic          clk = 1'b0;
   logic          clr;
   logic          ce = 1'b0;
   logic          en_in = 1'b0;
   logic          en_pc = 1'b0;
   logic          jmp_en = 1'b0;
   logic [AW-1:0] jmp_addr = '0;
   logic          mem_rd_req;
   logic [AW-1:0] mem_addr;
   logic          mem_rd_ack = 1'b0;
   logic [DW-1:0] mem_rdata;
   logic [DW-1:0] ir;
   logic [AW-1:0] pc;
   logic          stall;
   logic          fetch_done;
   logic          fetch_err;

   logic [DW-1:0] ram [16];

   int checks = 0;
   int errors = 0;

   // behavioural model state
   bit m_busy = 0;
   int m_waited = 0;
   int m_pc = 0;
   int m_addr = 0;
   int m_ir = 0;
   bit m_done = 0;
   bit m_err = 0;

   fetch_unit #(
      .AW       (AW),
      .DW       (DW),
      .RESET_PC (0),
      .MAX_WAIT (MAXW),
      .NOP_WORD (8'h00)
   ) dut (
      .clk        (clk),
      .clr        (clr),
      .ce         (ce),
      .en_in      (en_in),
      .en_pc      (en_pc),
      .jmp_en     (jmp_en),
      .jmp_addr   (jmp_addr),
      .mem_rd_req (mem_rd_req),
      .mem_addr   (mem_addr),
      .mem_rd_ack (mem_rd_ack),
      .mem_rdata  (mem_rdata),
      .ir         (ir),
      .pc         (pc),
      .stall      (stall),
      .fetch_done (fetch_done),
      .fetch_err  (fetch_err)
   );

   assign mem_rdata = ram[mem_addr];

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: a fetch is either outstanding or not; PC moves only when none is.
   always @(posedge clk or posedge clr) begin
      if (clr) begin
         m_busy = 0; m_waited = 0; m_pc = 0; m_addr = 0;
         m_ir = 0; m_done = 0; m_err = 0;
      end else begin
         m_done = 0;
         if (!m_busy) begin
            if (ce && en_in) begin
               m_addr = m_pc;
               m_busy = 1;
               m_waited = 0;
            end
            if (ce && jmp_en)
               m_pc = int'(jmp_addr);
            else if (ce && en_pc)
               m_pc = (m_pc + 1) % (1 << AW);
         end else begin
            m_waited++;
            if (mem_rd_ack) begin
               m_ir = int'(ram[m_addr]);
               m_busy = 0;
               m_done = 1;
            end else if (m_waited == MAXW) begin
               m_ir = 0;
               m_err = 1;
               m_busy = 0;
               m_done = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("req", int'(mem_rd_req), int'(m_busy));
      chk("stall", int'(stall), int'(m_busy));
      chk("pc", int'(pc), m_pc);
      chk("ir", int'(ir), m_ir);
      chk("done", int'(fetch_done), int'(m_done));
      chk("err", int'(fetch_err), int'(m_err));
      if (m_busy) chk("addr", int'(mem_addr), m_addr);
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Issue one fetch; raise ack after ack_at stall cycles (-1: never).
   task automatic run_fetch(input int ack_at, input bit pulse_pc, output int cnt);
      en_in = 1'b1;
      step();
      en_in = 1'b0;
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (!stall) break;
         cnt++;
         en_pc = (pulse_pc && k == 0);
         if (k == ack_at) mem_rd_ack = 1'b1;
         step();
      end
      en_pc = 1'b0;
   endtask

   int cnt;

   initial begin
      for (int i = 0; i < 16; i++) ram[i] = 8'(8'h10 + i);
      ram[3] = 8'hA5;
      ram[9] = 8'h5A;
      clr = 1'b1;
      #12 clr = 1'b0;
      step();

      // 1: mid-cycle reset pulse
      ce = 1'b1; jmp_en = 1'b1; jmp_addr = 4'd6;
      step();
      jmp_en = 1'b0;
      clr = 1'b1;
      #1;
      chk("t1_pc", int'(pc), 0);
      chk("t1_ir", int'(ir), 0);
      chk("t1_stall", int'(stall), 0);
      chk("t1_req", int'(mem_rd_req), 0);
      #1 clr = 1'b0;
      step();

      // 2: zero-wait fetch from pc=3
      jmp_en = 1'b1; jmp_addr = 4'd3;
      step();
      jmp_en = 1'b0;
      mem_rd_ack = 1'b1;
      en_in = 1'b1;
      step();
      en_in = 1'b0;
      chk("t2_req", int'(mem_rd_req), 1);
      chk("t2_stall", int'(stall), 1);
      chk("t2_addr", int'(mem_addr), 3);
      step();
      chk("t2_ir", int'(ir), 8'hA5);
      chk("t2_done", int'(fetch_done), 1);
      chk("t2_stall_off", int'(stall), 0);
      step();
      chk("t2_done_once", int'(fetch_done), 0);
      mem_rd_ack = 1'b0;

      // 3: three wait states, en_pc during stall dropped
      ram[3] = 8'h3C;
      run_fetch(3, 1'b1, cnt);
      mem_rd_ack = 1'b0;
      chk("t3_stall_cycles", cnt, 4);
      chk("t3_ir", int'(ir), 8'h3C);
      chk("t3_pc", int'(pc), 3);
      chk("t3_done", int'(fetch_done), 1);
      step();

      // 4: timeout
      run_fetch(-1, 1'b0, cnt);
      chk("t4_stall_cycles", cnt, 7);
      chk("t4_ir", int'(ir), 0);
      chk("t4_err", int'(fetch_err), 1);
      chk("t4_done", int'(fetch_done), 1);
      step();
      chk("t4_err_sticky", int'(fetch_err), 1);

      // 5: wrap, priority, and same-edge fetch + increment
      jmp_en = 1'b1; jmp_addr = 4'd15;
      step();
      jmp_en = 1'b0; en_pc = 1'b1;
      step();
      chk("t5_wrap", int'(pc), 0);
      jmp_en = 1'b1; jmp_addr = 4'd9;
      step();
      jmp_en = 1'b0; en_pc = 1'b0;
      chk("t5_prio", int'(pc), 9);
      mem_rd_ack = 1'b1; en_in = 1'b1; en_pc = 1'b1;
      step();
      en_in = 1'b0; en_pc = 1'b0;
      chk("t5_addr_old", int'(mem_addr), 9);
      chk("t5_pc_inc", int'(pc), 10);
      step();
      chk("t5_ir", int'(ir), 8'h5A);
      chk("t5_err_still", int'(fetch_err), 1);
      mem_rd_ack = 1'b0;
      step();

      // 6: reset during an outstanding request
      en_in = 1'b1;
      step();
      en_in = 1'b0;
      step();
      clr = 1'b1;
      #1;
      chk("t6_req", int'(mem_rd_req), 0);
      chk("t6_ir", int'(ir), 0);
      step();
      clr = 1'b0;
      step();
      mem_rd_ack = 1'b1;
      step();
      step();
      chk("t6_req_after", int'(mem_rd_req), 0);
      chk("t6_ir_after", int'(ir), 0);
      chk("t6_done", int'(fetch_done), 0);
      chk("t6_pc", int'(pc), 0);
      chk("t6_err", int'(fetch_err), 0);
      mem_rd_ack = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
